// File: rtl/risc_v_pkg.sv
// Shared definitions for the RISC-V boot path: datapath width and the
// instruction-memory loader state encoding.
package risc_v_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words. word_full flags the
// byte that completes the current word, so the caller can act next cycle.
module word_assembler
    import risc_v_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic [XLEN-1:0] word,
    output logic            word_full
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (byte_valid) begin
            word[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx                      <= byte_idx + 2'd1;
        end
    end

    assign word_full = byte_valid && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program image into instruction memory while holding
// the CPU in reset; releases the CPU only after a complete, error-free load.
module imem_loader
    import risc_v_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int              IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    generate
        if ((2 ** ADDR_W) < MEM_DEPTH) begin : g_addr_check
            $error("imem_loader: ADDR_W too narrow for MEM_DEPTH");
        end
    endgenerate

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   wc_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [IDLE_W-1:0] idle_q;

    logic start_ok, wc_bad, xfer, last_word, timeout_hit, word_full, asm_clear;

    assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign wc_bad      = (word_count == '0) || (word_count > DEPTH_LIM);
    assign xfer        = byte_valid && byte_ready;
    assign last_word   = ({1'b0, word_idx_q} == (wc_q - 1'b1));
    assign timeout_hit = !xfer && (idle_q == IDLE_W'(TIMEOUT - 1));
    // Any state outside RECV drops a partially assembled word.
    assign asm_clear   = (state_q != ST_RECV);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (xfer),
        .byte_data  (byte_data),
        .word       (imem_wdata),
        .word_full  (word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) state_d = wc_bad ? ST_ERR : ST_RECV;
            end
            ST_RECV: begin
                if (word_full)        state_d = ST_WRITE;
                else if (timeout_hit) state_d = ST_ERR;
            end
            ST_WRITE: state_d = last_word ? ST_DONE : ST_RECV;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wc_q       <= '0;
            word_idx_q <= '0;
            idle_q     <= '0;
        end else begin
            if (start_ok && !wc_bad) begin
                wc_q       <= word_count;
                word_idx_q <= '0;
                idle_q     <= '0;
            end else if (state_q == ST_RECV) begin
                idle_q <= xfer ? '0 : idle_q + 1'b1;
            end else if (state_q == ST_WRITE && !last_word) begin
                word_idx_q <= word_idx_q + 1'b1;
                idle_q     <= '0;
            end
        end
    end

    assign byte_ready = (state_q == ST_RECV);
    assign imem_we    = (state_q == ST_WRITE);
    assign imem_waddr = word_idx_q;
    assign busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign cpu_rst    = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and popped by a monitor on every imem_we pulse.
module tb_imem_loader;

    localparam int ADDR_W    = 10;
    localparam int MEM_DEPTH = 1024;
    localparam int TO        = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready, imem_we, cpu_rst, busy, done, err;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    wr_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  gaps[12]   = '{0, 3, 1, 5, 2, 0, 4, 1, 0, 5, 3, 2};

    imem_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst && imem_we) begin
                check("byte_ready_in_write", 32'(byte_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             imem_waddr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(imem_waddr), 32'(e.addr));
                    check("write_data", imem_wdata, e.data);
                end
            end
        end
    endtask

    task automatic do_start(input logic [ADDR_W:0] wc);
        @(negedge clk);
        word_count = wc;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        int n;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = d;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL byte_ready_wait: byte_ready stayed 0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gidx);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], (gidx >= 0) ? gaps[gidx + k] : 0);
        end
    endtask

    task automatic wait_end();
        int n;
        byte_valid = 1'b0;
        n = 0;
        while (!(done || err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL load_end_wait: neither done nor err after %0d cycles, expected one", n);
        end
    endtask

    initial begin
        logic [31:0] words[3];
        int n;
        words = '{32'h1122_3344, 32'hA5A5_0F0F, 32'h8000_0001};

        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached, expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        #12;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_waddr", 32'(imem_waddr), 32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_cpu_rst",    32'(cpu_rst),    32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single word
        exp_q.push_back('{addr: 10'd0, data: 32'h0050_0013});
        do_start(11'd1);
        check("single_busy", 32'(busy), 32'd1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        wait_end();
        check("single_done",    32'(done),    32'd1);
        check("single_err",     32'(err),     32'd0);
        check("single_cpu_rst", 32'(cpu_rst), 32'd0);
        check("single_busy_end", 32'(busy),   32'd0);

        // Three words with gaps; a start during the load is ignored
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{addr: ADDR_W'(i), data: words[i]});
        do_start(11'd3);
        do_start(11'd1);
        check("ignored_start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++)
            send_word(words[i], 4 * i);
        wait_end();
        check("three_done",    32'(done),    32'd1);
        check("three_cpu_rst", 32'(cpu_rst), 32'd0);
        check("three_drained", 32'(exp_q.size()), 32'd0);

        // Illegal word counts
        do_start(11'd0);
        check("wc0_err",     32'(err),     32'd1);
        check("wc0_done",    32'(done),    32'd0);
        check("wc0_cpu_rst", 32'(cpu_rst), 32'd1);
        do_start(11'(MEM_DEPTH + 1));
        check("wcmax_err",  32'(err),  32'd1);
        check("wcmax_busy", 32'(busy), 32'd0);

        // Timeout after two bytes
        do_start(11'd2);
        check("to_err_cleared", 32'(err), 32'd0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        byte_valid = 1'b0;
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TO));
        check("timeout_busy",   32'(busy), 32'd0);

        // Recovery load after the timeout
        exp_q.push_back('{addr: 10'd0, data: 32'hDEAD_BEEF});
        do_start(11'd1);
        send_word(32'hDEAD_BEEF, -1);
        wait_end();
        check("recover_done", 32'(done), 32'd1);
        check("recover_err",  32'(err),  32'd0);

        // Reset in the middle of word 1
        exp_q.push_back('{addr: 10'd0, data: 32'h0BAD_C0DE});
        do_start(11'd2);
        send_word(32'h0BAD_C0DE, -1);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        byte_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_busy",       32'(busy),       32'd0);
        check("midrst_cpu_rst",    32'(cpu_rst),    32'd1);
        check("midrst_byte_ready", 32'(byte_ready), 32'd0);
        check("midrst_imem_we",    32'(imem_we),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Fresh load after reset must start from an empty packer
        exp_q.push_back('{addr: 10'd0, data: 32'hCAFE_F00D});
        do_start(11'd1);
        send_word(32'hCAFE_F00D, -1);
        wait_end();
        check("postrst_done", 32'(done), 32'd1);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, gives the instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 10, gives the word-address width; the block SHALL require 2**ADDR_W >= MEM_DEPTH.
REQ-003 Parameter TIMEOUT, default 4096, gives the maximum idle cycles allowed between bytes inside a load.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 start  input  1  one-cycle load request, sampled only in IDLE, DONE or ERR.
REQ-007 word_count  input  ADDR_W+1  number of words to load; latched on an accepted start.
REQ-008 byte_valid  input  1  upstream byte present.
REQ-009 byte_data  input  8  upstream byte.
REQ-010 byte_ready  output  1  block accepts a byte this cycle.
REQ-011 imem_we  output  1  instruction-memory write strobe.
REQ-012 imem_waddr  output  ADDR_W  word address of the write.
REQ-013 imem_wdata  output  32  word to write.
REQ-014 cpu_rst  output  1  active-high reset held on the processor.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  last load completed.
REQ-017 err  output  1  last load failed.

Function
REQ-018 The block SHALL implement the FSM states IDLE, RECV, WRITE, DONE and ERR.
REQ-019 On an accepted start, the block SHALL go to ERR if word_count is 0 or greater than MEM_DEPTH; otherwise it SHALL go to RECV with word index 0 and byte index 0.
REQ-020 A byte transfers when byte_valid and byte_ready are both 1; byte_ready SHALL be 1 only in RECV.
REQ-021 Bytes SHALL pack little-endian: byte k of a word goes to bits [8k+7:8k].
REQ-022 The cycle after the 4th byte of a word transfers, the block SHALL be in WRITE for exactly 1 cycle with imem_we=1, imem_waddr equal to the word index, and imem_wdata equal to the packed word.
REQ-023 imem_we SHALL be 0 in every state other than WRITE.
REQ-024 From WRITE, the block SHALL go to DONE if the word index equals the latched word_count-1; otherwise it SHALL increment the word index and return to RECV.
REQ-025 In RECV, an idle counter SHALL count cycles with no byte transfer and clear on every transfer.
REQ-026 When the idle counter reaches TIMEOUT, the block SHALL go to ERR.
REQ-027 Words written before an error SHALL remain in memory; the block SHALL NOT roll them back.
REQ-028 Output encoding SHALL be: busy=1 in RECV/WRITE; done=1 only in DONE; err=1 only in ERR.
REQ-029 cpu_rst SHALL be 1 in every state except DONE.
REQ-030 A start in DONE or ERR SHALL restart a load per REQ-019, clearing done and err.
REQ-031 A start in RECV or WRITE SHALL be ignored.
REQ-032 Changes to word_count after it is latched SHALL have no effect on the load in progress.

Reset
REQ-033 Asserting rst at any time, including mid-word, SHALL asynchronously force IDLE.
REQ-034 Reset SHALL clear all counters and the packing register.
REQ-035 Reset values: byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, err=0, cpu_rst=1.
REQ-036 A partially assembled word SHALL be discarded on reset and never written.

Structure
REQ-037 The state enumeration and XLEN=32 SHALL live in the shared package risc_v_pkg.
REQ-038 Byte packing SHALL be a sub-module word_assembler: byte in, valid in, clear in, 32-bit word out, word_full out.
REQ-039 The write port SHALL connect to a write port on instruction_memory, matching its ADDR_W indexing (byte address [11:2]).

Verification
REQ-040 Single word: word_count=1, bytes 0x13,0x00,0x50,0x00 -> one WRITE with addr 0, wdata 0x00500013; then done=1, cpu_rst=0.
REQ-041 Three words with byte_valid gaps of 0-5 cycles -> exactly 3 imem_we pulses at addresses 0,1,2 with correct data; byte_ready is 0 during each WRITE cycle.
REQ-042 word_count=0 and word_count=MEM_DEPTH+1 -> ERR in 1 cycle, err=1, no imem_we pulse.
REQ-043 TIMEOUT=16, stall after 2 bytes -> ERR after 16 idle cycles; a following start with valid stimulus loads correctly.
REQ-044 rst asserted after 2 bytes of word 1 -> immediate IDLE, cpu_rst=1, no write for the partial word; a start during a load is ignored.
